// File: rtl/mwadd_pkg.sv
// Shared definitions for the word-serial multi-word adder: FSM states and index sizing.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORDS_DEF = 4;
  localparam int IDX_W     = $clog2(WORDS_DEF);

  // Index width for an arbitrary word count; never narrower than one bit.
  function automatic int idx_width(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/multiword_add_seq_adder.sv
// Combinational WIDTH-bit ripple-carry adder with carry-out and signed-overflow flag.
module rippleCarryAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co  = c[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial WIDTH*WORDS adder/subtractor: one word per cycle through a single shared adder.
// Subtraction is only built when MWADD_SUB_EN is defined; otherwise the sub port is ignored.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IW = idx_width(WORDS);

  typedef logic [WORDS-1:0][WIDTH-1:0] words_t;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  words_t        a_q, a_d;
  words_t        b_q, b_d;
  words_t        sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          sub_in;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_s;
  logic          add_co;
  logic          add_ovf;

`ifdef MWADD_SUB_EN
  logic sub_q, sub_d;

  assign sub_in = sub;
  assign add_y  = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign sub_in     = 1'b0;
  assign add_y      = b_q[idx_q];
`endif

  rippleCarryAdder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .x  (a_q[idx_q]),
    .y  (add_y),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co),
    .ovf(add_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef MWADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          // Subtraction is A + ~B + 1, so word 0 always gets a carry-in of 1.
          carry_d = sub_in ? 1'b1 : cin;
`ifdef MWADD_SUB_EN
          sub_d   = sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_s;
        carry_d      = add_co;
        idx_d        = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_co;
          ovf_d   = add_ovf;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef MWADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (WIDTH=8, WORDS=4) against a full-width arithmetic model.
module tb_multiword_add_seq;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(
    .WIDTH(W),
    .WORDS(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy)
  );

  // Full-width reference: {overflow, cout, sum}.
  function automatic logic [TW+1:0] model(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                          input logic ci, input logic s);
    logic          se;
    logic [TW-1:0] yp;
    logic [TW:0]   r;
    logic          ov;
`ifdef MWADD_SUB_EN
    se = s;
`else
    se = 1'b0;
`endif
    yp = se ? ~y : y;
    r  = {1'b0, x} + {1'b0, yp} + {{TW{1'b0}}, (se ? 1'b1 : ci)};
    ov = (x[TW-1] == yp[TW-1]) && (r[TW-1] != x[TW-1]);
    return {ov, r[TW], r[TW-1:0]};
  endfunction

  // Issues one request from IDLE and waits for out_valid; lat counts cycles from the handshake cycle.
  task automatic run_op(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic ci,
                        input logic s, output int lat);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h cout=%b ovf=%b, want 0 0 0", sum, cout, overflow);
    end
  endtask

  task automatic test_directed();
    logic [TW-1:0] va [4];
    logic [TW-1:0] vb [4];
    logic          vs [4];
    logic [TW-1:0] es [4];
    logic          ec [4];
    logic          eo [4];
    int            lat;
    va[0] = 32'h0000_00FF; vb[0] = 32'h0000_0001; vs[0] = 1'b0; es[0] = 32'h0000_0100; ec[0] = 1'b0; eo[0] = 1'b0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vs[1] = 1'b0; es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = 1'b0; es[2] = 32'h8000_0000; ec[2] = 1'b0; eo[2] = 1'b1;
    va[3] = 32'h0000_0005; vb[3] = 32'h0000_0007; vs[3] = 1'b1; ec[3] = 1'b0; eo[3] = 1'b0;
`ifdef MWADD_SUB_EN
    es[3] = 32'hFFFF_FFFE;
`else
    es[3] = 32'h0000_000C;
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b0, vs[i], lat);
      checks++;
      if (lat !== N + 1) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, N + 1);
      end
      checks++;
      if (sum !== es[i] || cout !== ec[i] || overflow !== eo[i]) begin
        errors++;
        $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, sum, cout, overflow, es[i], ec[i], eo[i]);
      end
      ack();
    end
  endtask

  task automatic test_hold();
    logic [TW-1:0] x, y;
    logic          ci, s;
    logic [TW+1:0] exp;
    int            lat;
    x = $urandom; y = $urandom; ci = 1'($urandom); s = 1'($urandom);
    exp = model(x, y, ci, s);
    run_op(x, y, ci, s, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      checks++;
      if ({overflow, cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: ovf/cout/sum=%h vld=%b rdy=%b, want %h 1 0",
                 i, {overflow, cout, sum}, out_valid, in_ready, exp);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ack();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] x, y;
    logic [TW+1:0] exp;
    int            lat;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b sum=%h in_ready=%b busy=%b, want 0 0 1 0",
               out_valid, sum, in_ready, busy);
    end
    x = $urandom; y = $urandom;
    exp = model(x, y, 1'b1, 1'b0);
    run_op(x, y, 1'b1, 1'b0, lat);
    checks++;
    if ({overflow, cout, sum} !== exp || lat !== N + 1) begin
      errors++;
      $display("FAIL midreset_next: ovf/cout/sum=%h lat=%0d, want %h %0d", {overflow, cout, sum}, lat, exp, N + 1);
    end
    ack();
  endtask

  task automatic test_random();
    logic [TW-1:0] x, y;
    logic          ci, s;
    logic [TW+1:0] exp;
    int            lat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; ci = 1'($urandom); s = 1'($urandom);
      if (i % 4 == 0) y = ~x;
      exp = model(x, y, ci, s);
      run_op(x, y, ci, s, lat);
      checks++;
      if ({overflow, cout, sum} !== exp || lat !== N + 1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d: ovf/cout/sum=%h lat=%0d busy=%b, want %h %0d 1",
                 i, {overflow, cout, sum}, lat, busy, exp, N + 1);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the shared adder datapath, one word per cycle.
REQ-002 Parameter WORDS, default 4, legal range 2..16: number of words per operand; total operand width is WIDTH*WORDS.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request carries valid operands.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH*WORDS  operand A, word 0 is the least significant.
REQ-008 b  input  WIDTH*WORDS  operand B, word 0 is the least significant.
REQ-009 cin  input  1  carry into word 0 for an add operation.
REQ-010 sub  input  1  operation select: 1 = A-B, 0 = A+B.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH*WORDS  result.
REQ-014 cout  output  1  carry out of the top word.
REQ-015 overflow  output  1  two's-complement overflow of the full-width result.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1; in_valid=1 captures a, b, cin and sub, clears word index to 0, and moves to RUN.
REQ-019 RUN: each cycle adds word[idx] of A with word[idx] of B' on one WIDTH-bit ripple adder; B' = ~B when sub=1, else B.
REQ-020 Carry into word 0 = (sub ? 1 : cin); carry into word k>0 = registered carry out of word k-1.
REQ-021 Word result goes to sum word[idx]; idx increments; after word WORDS-1 the FSM moves to DONE.
REQ-022 On entering DONE, cout = final adder carry and overflow = the adder overflow of the top word.
REQ-023 Latency: a handshake at cycle T gives out_valid=1 at cycle T+WORDS+1.
REQ-024 DONE: out_valid=1; sum, cout and overflow stay stable until out_ready=1, then return to IDLE.
REQ-025 in_ready=0 in RUN and DONE; in_valid is ignored there; there is no pipelining of requests.
REQ-026 out_valid and out_ready both high in DONE: IDLE is entered next cycle; a new request is accepted no earlier than that IDLE cycle.
REQ-027 Carry wraps only out of the top word into cout; there is no modular wrap of idx beyond WORDS-1.
REQ-028 Captured operands are not affected by input changes after the handshake.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, idx=0, carry=0, sum=0, cout=0, overflow=0, out_valid=0 and in_ready=1, regardless of state.
REQ-030 Reset during RUN or DONE abandons the operation with no partial output.

Configuration
REQ-031 Macro MWADD_SUB_EN: when defined, sub behaves as in REQ-010 and REQ-019.
REQ-032 When MWADD_SUB_EN is undefined: the sub port remains, is ignored and treated as 0, only addition is performed, and the inverter logic is absent.

Structure
REQ-033 Shared package mwadd_pkg holds the FSM state enum (IDLE, RUN, DONE) and the constant IDX_W = clog2(WORDS).
REQ-034 Sub-module: exactly one instance of rippleCarryAdder #(WIDTH), used as the shared datapath; no other adder logic is present.

Verification
REQ-035 WIDTH=8, WORDS=4, A=0x000000FF, B=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, overflow=0, out_valid exactly 5 cycles after the handshake.
REQ-036 A=0xFFFFFFFF, B=0x00000001, add -> sum=0x00000000, cout=1, overflow=0 (carry ripples through all words).
REQ-037 A=0x7FFFFFFF, B=0x00000001, add -> sum=0x80000000, overflow=1, cout=0.
REQ-038 MWADD_SUB_EN defined, A=0x00000005, B=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0; with the macro undefined -> sum=0x0000000C.
REQ-039 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-040 rst asserted in the second RUN cycle -> next cycle IDLE, out_valid=0, sum=0; a following request completes correctly.
